// File: rtl/mips_stage_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and the surrounding datapath blocks.
// The sequencer connects through the slave modport and its environment through the master modport.
interface mips_stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             jflag;
    logic             br_taken;
    logic [1:0]       mem_op;
    logic             wb_req;
    logic             mem_ready;
    logic             if_en;
    logic             id_en;
    logic             ex_en;
    logic             mem_en;
    logic             wb_en;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             busy;
    logic             mem_err;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  start, halt_req, jflag, br_taken, mem_op, wb_req, mem_ready,
        output if_en, id_en, ex_en, mem_en, wb_en, pc_we, pc_sel, busy, mem_err, retired
    );

    modport master (
        output start, halt_req, jflag, br_taken, mem_op, wb_req, mem_ready,
        input  if_en, id_en, ex_en, mem_en, wb_en, pc_we, pc_sel, busy, mem_err, retired
    );
endinterface

// File: rtl/mips_stage_sequencer.sv
// Multicycle MIPS control FSM: steps fetch/decode/execute/memory/writeback, picks the next-PC
// source, counts retired instructions and traps data-memory timeouts.
module mips_stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_jmp_q;
    logic             r_br_q;
    logic             r_wbr_q;
    logic [1:0]       r_mop_q;
    logic             r_halt_pend;
    logic [7:0]       r_wait;
    logic             r_if_en;
    logic             r_id_en;
    logic             r_ex_en;
    logic             r_mem_en;
    logic             r_wb_en;
    logic             r_pc_we;
    logic [1:0]       r_pc_sel;
    logic             r_busy;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_retired;

    logic w_mop_mem;
    logic w_busy_state;
    logic w_br_next;
    logic w_mem_timeout;

    assign w_mop_mem     = (r_mop_q == 2'b01) || (r_mop_q == 2'b10);
    assign w_busy_state  = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign w_mem_timeout = (r_wait == 8'(MEM_TIMEOUT - 1));
    // The branch flag is being latched on the same edge that enters WRITEBACK from EXECUTE.
    assign w_br_next     = (r_state == S_EXECUTE) ? bus.br_taken : r_br_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.start) w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE:   w_next = w_mop_mem ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (bus.mem_ready)  w_next = S_WRITEBACK;
                else if (w_mem_timeout) w_next = S_ERROR;
            end
            S_WRITEBACK: w_next = (r_halt_pend || bus.halt_req) ? S_IDLE : S_FETCH;
            S_ERROR:     w_next = S_ERROR;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_jmp_q     <= 1'b0;
            r_br_q      <= 1'b0;
            r_wbr_q     <= 1'b0;
            r_mop_q     <= 2'b00;
            r_halt_pend <= 1'b0;
            r_wait      <= 8'd0;
            r_if_en     <= 1'b0;
            r_id_en     <= 1'b0;
            r_ex_en     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_wb_en     <= 1'b0;
            r_pc_we     <= 1'b0;
            r_pc_sel    <= 2'b00;
            r_busy      <= 1'b0;
            r_mem_err   <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_DECODE) begin
                r_jmp_q <= bus.jflag;
                r_mop_q <= bus.mem_op;
                r_wbr_q <= bus.wb_req;
            end
            if (r_state == S_EXECUTE) r_br_q <= bus.br_taken;

            r_wait <= (r_state == S_MEMORY) ? r_wait + 8'd1 : 8'd0;

            if (r_state == S_WRITEBACK) r_retired <= r_retired + CNT_W'(1);

            if (r_state == S_WRITEBACK && w_next == S_IDLE) r_halt_pend <= 1'b0;
            else if (bus.halt_req && w_busy_state)          r_halt_pend <= 1'b1;

            // Outputs are registered from the state being entered, so they are a Moore decode.
            r_if_en   <= (w_next == S_FETCH);
            r_id_en   <= (w_next == S_DECODE);
            r_ex_en   <= (w_next == S_EXECUTE);
            r_mem_en  <= (w_next == S_MEMORY);
            r_pc_we   <= (w_next == S_WRITEBACK);
            r_wb_en   <= (w_next == S_WRITEBACK) && r_wbr_q && (r_mop_q != 2'b10);
            r_pc_sel  <= (w_next != S_WRITEBACK) ? 2'b00 :
                         r_jmp_q                  ? 2'b01 :
                         w_br_next                ? 2'b10 : 2'b00;
            r_busy    <= (w_next != S_IDLE) && (w_next != S_ERROR);
            r_mem_err <= (w_next == S_ERROR);
        end
    end

    assign bus.if_en   = r_if_en;
    assign bus.id_en   = r_id_en;
    assign bus.ex_en   = r_ex_en;
    assign bus.mem_en  = r_mem_en;
    assign bus.wb_en   = r_wb_en;
    assign bus.pc_we   = r_pc_we;
    assign bus.pc_sel  = r_pc_sel;
    assign bus.busy    = r_busy;
    assign bus.mem_err = r_mem_err;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Scoreboard bench for mips_stage_sequencer: directed instructions push their expected writeback
// result, and a negedge monitor checks each writeback as the sequencer presents it.
module tb_mips_stage_sequencer;
    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct {
        int pc_sel;
        int wb;
        int len;
        int k;
        int ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_ret = 0;
    exp_t q[$];

    mips_stage_sequencer_if #(.CNT_W(CW)) bus ();

    mips_stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: instruction length, memory cycles and writeback fields checked at each pc_we.
    int cyc = 0;
    int fetch_cyc = 0;
    int mem_k = 0;
    always @(negedge clk) begin
        exp_t e;
        int   ones;
        if (!rst) begin
            cyc++;
            if (bus.if_en) begin
                fetch_cyc = cyc;
                mem_k = 0;
            end
            if (bus.mem_en) mem_k++;
            ones = int'(bus.if_en) + int'(bus.id_en) + int'(bus.ex_en) + int'(bus.mem_en)
                 + int'(bus.pc_we | bus.wb_en);
            chk("one_strobe", ones, bus.busy ? 1 : 0);
            if (bus.pc_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_writeback", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pc_sel", int'(bus.pc_sel), e.pc_sel);
                    chk("wb_en", int'(bus.wb_en), e.wb);
                    chk("instr_len", cyc - fetch_cyc + 1, e.len);
                    chk("mem_cycles", mem_k, e.k);
                    chk("retired_in_wb", int'(bus.retired), e.ret);
                end
            end
        end
    end

    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("fetch_after_start", int'(bus.if_en), 1);
    endtask

    // halt: 0 none, 1 pulse during EXECUTE, 2 pulse during WRITEBACK. k: MEMORY cycle giving mem_ready.
    task automatic instr(input bit j, input bit b, input logic [1:0] mop, input bit wbr,
                         input int k, input int halt);
        exp_t e;
        bit   is_mem;
        bit   seen;
        bit   done;
        int   cnt;
        is_mem   = (mop == 2'b01) || (mop == 2'b10);
        e.pc_sel = j ? 1 : (b ? 2 : 0);
        e.wb     = (wbr && mop != 2'b10) ? 1 : 0;
        e.k      = is_mem ? k : 0;
        e.len    = 4 + e.k;
        e.ret    = exp_ret % 16;
        q.push_back(e);
        bus.jflag = j;
        bus.br_taken = b;
        bus.mem_op = mop;
        bus.wb_req = wbr;
        cnt = 0;
        seen = 0;
        done = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            if (bus.if_en) seen = 1;
            if (seen && bus.pc_we) begin
                done = 1;
                if (halt == 2) bus.halt_req = 1'b1;
            end else begin
                if (bus.mem_en) begin
                    cnt++;
                    bus.mem_ready = (cnt == k);
                end else begin
                    bus.mem_ready = 1'b0;
                end
                bus.halt_req = (halt == 1) && bus.ex_en;
                @(negedge clk);
            end
        end
        if (!done) chk("writeback_timeout", 0, 1);
        exp_ret++;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        bus.halt_req = 1'b0;
        bus.mem_ready = 1'b0;
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_if_en"}, int'(bus.if_en), 0);
        chk({name, "_retired"}, int'(bus.retired), exp_ret % 16);
    endtask

    initial begin
        int mk;
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        bus.jflag = 1'b0;
        bus.br_taken = 1'b0;
        bus.mem_op = 2'b00;
        bus.wb_req = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_if_en", int'(bus.if_en), 0);
        chk("rst_pc_we", int'(bus.pc_we), 0);
        chk("rst_mem_err", int'(bus.mem_err), 0);
        chk("rst_retired", int'(bus.retired), 0);
        rst = 1'b0;

        // Plain ALU op, then lw with ready on 3rd MEMORY cycle and halt during its EXECUTE.
        kick();
        instr(1'b0, 1'b0, 2'b00, 1'b1, 0, 0);
        @(negedge clk);
        chk("back_to_back_fetch", int'(bus.if_en), 1);
        chk("retired_after_1", int'(bus.retired), 1);
        instr(1'b0, 1'b0, 2'b01, 1'b1, 3, 1);
        check_idle("halt_ex");

        // halt_req in IDLE must not stop the following instruction.
        bus.halt_req = 1'b1;
        @(negedge clk);
        bus.halt_req = 1'b0;
        kick();
        instr(1'b1, 1'b1, 2'b00, 1'b1, 0, 0);
        instr(1'b0, 1'b1, 2'b00, 1'b0, 0, 0);
        instr(1'b0, 1'b0, 2'b10, 1'b1, 1, 0);
        instr(1'b0, 1'b1, 2'b11, 1'b1, 0, 0);
        instr(1'b1, 1'b0, 2'b01, 1'b0, 2, 2);
        check_idle("halt_wb");

        // Nine more instructions bring the total to 16 and wrap the 4-bit counter.
        kick();
        for (int i = 0; i < 8; i++) instr(i[0], i[1], 2'b00, 1'b1, 0, 0);
        instr(1'b0, 1'b0, 2'b00, 1'b1, 0, 2);
        check_idle("wrap");
        chk("retired_wrap", int'(bus.retired), 0);

        // sw that never sees mem_ready: timeout into ERROR.
        bus.mem_op = 2'b10;
        bus.wb_req = 1'b1;
        kick();
        mk = 0;
        for (int t = 0; t < 40; t++) begin
            if (bus.mem_en) mk++;
            else if (mk > 0) break;
            @(negedge clk);
        end
        chk("timeout_mem_cycles", mk, TO);
        chk("err_mem_err", int'(bus.mem_err), 1);
        chk("err_busy", int'(bus.busy), 0);
        chk("err_wb_en", int'(bus.wb_en), 0);
        chk("err_retired", int'(bus.retired), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_start_ignored", int'(bus.if_en), 0);
        chk("err_sticky", int'(bus.mem_err), 1);

        // Reset clears ERROR; then abandon an lw in MEMORY with an asynchronous reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        chk("rst_clears_err", int'(bus.mem_err), 0);
        kick();
        instr(1'b0, 1'b0, 2'b00, 1'b1, 0, 2);
        check_idle("pre_abort");
        bus.mem_op = 2'b01;
        kick();
        mk = 0;
        for (int t = 0; t < 10 && !bus.mem_en; t++) @(negedge clk);
        chk("reached_memory", int'(bus.mem_en), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_en", int'(bus.mem_en), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_retired", int'(bus.retired), 0);
        chk("abort_pc_we", int'(bus.pc_we) + int'(bus.wb_en), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", int'(bus.busy), 0);
        chk("abort_no_pending", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_stage_sequencer.md
# mips_stage_sequencer

Multicycle control FSM for the 32-bit MIPS core. It steps one instruction at a time through fetch, decode, execute, memory and writeback by driving the per-stage `done`/enable strobes. It selects the next-PC source from the decoder's jump flag and the ALU's branch result, counts retired instructions, and flags data-memory timeouts. It sits beside the datapath, between the instruction fetch unit, `instr_decode`, the ALU, the data memory and the register file.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEMORY waiting for `mem_ready`, range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE.
- halt_req  in  1  stop after the current instruction retires.
- jflag  in  1  jump indication from the decoder; sampled in DECODE.
- br_taken  in  1  branch-condition result from the ALU; sampled in EXECUTE.
- mem_op  in  2  memory operation from the decoder: 00 none, 01 lw, 10 sw, 11 treated as none; sampled in DECODE.
- wb_req  in  1  instruction writes a register; sampled in DECODE.
- mem_ready  in  1  data memory access complete.
- if_en  out  1  fetch strobe.
- id_en  out  1  decode strobe, drives the decoder's `done_in`.
- ex_en  out  1  ALU strobe.
- mem_en  out  1  data memory request, held high while in MEMORY.
- wb_en  out  1  register-file write enable.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  next-PC select: 00 PC+4, 01 jump target, 10 branch target.
- busy  out  1  high whenever the state is not IDLE or ERROR.
- mem_err  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  count of instructions completed.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, ERROR.
- Outputs are a Moore decode of the registered state and the registered sampled flags. No output depends combinationally on any input.
- IDLE -> FETCH when `start`=1; otherwise stay in IDLE.
- FETCH: `if_en`=1. Next state is DECODE.
- DECODE: `id_en`=1. Latch `jmp_q`=`jflag`, `mop_q`=`mem_op`, `wbr_q`=`wb_req`. Next state is EXECUTE.
- EXECUTE: `ex_en`=1. Latch `br_q`=`br_taken`. Next state is MEMORY if `mop_q` is 01 or 10, otherwise WRITEBACK.
- MEMORY: `mem_en`=1.
  - A wait counter clears on entry.
  - If `mem_ready`=1, go to WRITEBACK.
  - Else, if the counter equals MEM_TIMEOUT-1, go to ERROR.
  - Else, increment the counter and stay.
  - `mem_ready` takes priority over the timeout in the same cycle.
- WRITEBACK:
  - `wb_en` = `wbr_q` AND (`mop_q` != 10).
  - `pc_we`=1.
  - `pc_sel` = 01 if `jmp_q`, else 10 if `br_q`, else 00. Jump has priority over branch.
  - `retired` increments by 1 and wraps modulo 2^CNT_W.
  - Next state is IDLE if `halt_pend`, otherwise FETCH.
- ERROR: all strobes are 0 and `mem_err`=1. The FSM leaves ERROR only on `rst`.
- `halt_pend`:
  - Set when `halt_req`=1 in any busy state.
  - Cleared on the WRITEBACK -> IDLE transition and by `rst`.
  - `halt_req` in IDLE is ignored.
- `start` outside IDLE is ignored.
- Exactly one of `if_en`, `id_en`, `ex_en`, `mem_en`, (`pc_we` or `wb_en`) is active in any cycle.

## Timing
- Reset: state is IDLE, and every output is 0, including `retired`. `halt_pend`, the sampled flags and the wait counter are all 0. Reset takes effect immediately (asynchronous) and releases on the next edge.
- Reset mid-instruction abandons the instruction with no `pc_we` or `wb_en` pulse and no counter increment.
- `start` high at edge N puts the FSM in FETCH for cycle N+1.
- Instruction with no memory access: 4 cycles (F, D, E, W).
- Memory instruction: 4 + k cycles, where k is the number of MEMORY cycles, 1 ≤ k ≤ MEM_TIMEOUT.
- Back-to-back instructions: FETCH directly follows WRITEBACK with no gap cycle.
- Every strobe is a one-cycle pulse per instruction, except `mem_en`, which stays high for k cycles.
- `mem_ready` is honoured only in MEMORY; it is ignored in all other states.
- Timeout: `mem_ready` absent for MEM_TIMEOUT consecutive MEMORY cycles means ERROR is entered on the next edge, and `mem_err` is high from that cycle on.
- `halt_req` arriving in the WRITEBACK cycle still takes effect: the next state is IDLE.
- `retired` at max value wraps to 0 on the next WRITEBACK.

## Test plan
- Reset, then `start`=1 for one cycle, with `mem_op`=00, `wb_req`=1, `jflag`=0, `br_taken`=0. Required: `if_en`, `id_en`, `ex_en`, then `wb_en`+`pc_we` on consecutive cycles 1–4; `pc_sel`=00; `retired`=1; FETCH again on cycle 5.
- lw instruction (`mem_op`=01, `wb_req`=1) with `mem_ready` asserted on the 3rd MEMORY cycle. Required: `mem_en` high for 3 cycles, then `wb_en`=1; the instruction takes 7 cycles in total.
- sw instruction (`mem_op`=10, `wb_req`=1) with MEM_TIMEOUT=4 and `mem_ready` never asserted. Required: `mem_en` high for exactly 4 cycles, then ERROR with `mem_err`=1, `busy`=0, no `wb_en`; `start` is ignored until `rst`.
- `jflag`=1 in DECODE and `br_taken`=1 in EXECUTE. Required: `pc_sel`=01 in WRITEBACK. Repeat with `jflag`=0: required `pc_sel`=10.
- `halt_req` pulsed during EXECUTE of instruction 2. Required: WRITEBACK completes with `retired`=2, then IDLE with `busy`=0; a later `start` resumes at FETCH.
- CNT_W=4 with 16 instructions run. Required: `retired` wraps to 0. Also assert `rst` during MEMORY: required immediate IDLE, all outputs 0.
